// File: rtl/lcd_pkg.sv
// lcd_pkg: shared state encoding, default HD44780 timing at 50 MHz and the
// long-execution command decode reused by the upstream sequencer.
// Timing constants are cycle counts; every one must be >= 1.
package lcd_pkg;

   typedef enum logic [2:0] {
      ST_POWERUP = 3'd0,
      ST_IDLE    = 3'd1,
      ST_SETUP   = 3'd2,
      ST_PULSE   = 3'd3,
      ST_HOLD    = 3'd4,
      ST_EXEC    = 3'd5
   } lcd_state_t;

   localparam int SETUP_CYC_DEF     = 4;       // tAS >= 40 ns
   localparam int EN_HIGH_CYC_DEF   = 12;      // EN width >= 230 ns
   localparam int HOLD_CYC_DEF      = 2;       // RS/DATA hold after EN falls
   localparam int EXEC_CYC_DEF      = 2000;    // 40 us
   localparam int LONG_EXEC_CYC_DEF = 82000;   // 1.64 ms, clear/home
   localparam int POR_CYC_DEF       = 750000;  // 15 ms power-on

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Clear display (0x01) and return home (0x02/0x03) need the long wait.
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
      return (!rs) && (data[7:2] == 6'd0);
   endfunction

endpackage

// File: rtl/lcd_bus_driver_if.sv
// lcd_bus_driver_if: byte request handshake between the sequencer (master)
// and the write-cycle engine (slave). A byte moves when req_valid && req_ready;
// wr_done pulses once when the byte's execution wait has elapsed.
interface lcd_bus_driver_if;

   logic       req_valid;
   logic       req_rs;
   logic [7:0] req_data;
   logic       req_ready;
   logic       wr_done;

   modport master (
      output req_valid,
      output req_rs,
      output req_data,
      input  req_ready,
      input  wr_done
   );

   modport slave (
      input  req_valid,
      input  req_rs,
      input  req_data,
      output req_ready,
      output wr_done
   );

endinterface

// File: rtl/lcd_delay_counter.sv
// lcd_delay_counter: loadable down-counter that stops at zero, with zero flag.
// Latency: load takes effect on the next edge; zero is decoded from the count.
// No backpressure; load wins over the decrement.
module lcd_delay_counter #(
   parameter int           W       = 20,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt;

   // Count register: reload on state entry, otherwise run down and park at 0.
   always_ff @(posedge clk) begin
      if (reset)
         cnt <= RST_VAL;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/lcd_bus_driver.sv
// lcd_bus_driver: HD44780 write-cycle engine, one byte per handshake, with
// fixed setup / EN-pulse / hold / execution waits. Optional power-on wait
// under LCD_BUS_POR_EN. req_ready is high only in IDLE; busy requests are dropped.
module lcd_bus_driver
   import lcd_pkg::*;
#(
   parameter int SETUP_CYC     = SETUP_CYC_DEF,
   parameter int EN_HIGH_CYC   = EN_HIGH_CYC_DEF,
   parameter int HOLD_CYC      = HOLD_CYC_DEF,
   parameter int EXEC_CYC      = EXEC_CYC_DEF,
   parameter int LONG_EXEC_CYC = LONG_EXEC_CYC_DEF,
   parameter int POR_CYC       = POR_CYC_DEF
) (
   input  logic                   CLOCK_50,
   input  logic                   reset,
   lcd_bus_driver_if.slave        bus,
   output logic                   LCD_RS,
   output logic                   LCD_RW,
   output logic                   LCD_EN,
   output logic [7:0]             LCD_DATA
);

   localparam int CNT_W = $clog2(max_int(POR_CYC, LONG_EXEC_CYC)) + 1;
   typedef logic [CNT_W-1:0] cnt_t;

`ifdef LCD_BUS_POR_EN
   // Counter comes out of reset already primed so POWERUP lasts POR_CYC cycles.
   localparam lcd_state_t RST_STATE = ST_POWERUP;
   localparam cnt_t       CNT_RST   = cnt_t'(POR_CYC - 1);
`else
   localparam lcd_state_t RST_STATE = ST_IDLE;
   localparam cnt_t       CNT_RST   = '0;
`endif

   lcd_state_t state, next_state;
   logic       accept;
   logic       cnt_zero;
   logic       cnt_load;
   cnt_t       cnt_load_val;
   logic       long_q;
   logic       en_nxt;
   logic       done_nxt;
   logic       done_q;

   assign accept = bus.req_valid && (state == ST_IDLE);

   lcd_delay_counter #(
      .W       (CNT_W),
      .RST_VAL (CNT_RST)
   ) u_delay (
      .clk      (CLOCK_50),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .zero     (cnt_zero)
   );

   // State register.
   always_ff @(posedge CLOCK_50) begin
      if (reset)
         state <= RST_STATE;
      else
         state <= next_state;
   end

   // Next-state: each timed state exits when the shared counter reaches zero.
   always_comb begin
      next_state = state;
      case (state)
`ifdef LCD_BUS_POR_EN
         ST_POWERUP: if (cnt_zero) next_state = ST_IDLE;
`endif
         ST_IDLE:    if (accept)   next_state = ST_SETUP;
         ST_SETUP:   if (cnt_zero) next_state = ST_PULSE;
         ST_PULSE:   if (cnt_zero) next_state = ST_HOLD;
         ST_HOLD:    if (cnt_zero) next_state = ST_EXEC;
         ST_EXEC:    if (cnt_zero) next_state = ST_IDLE;
         default:                  next_state = ST_IDLE;
      endcase
   end

   // Outputs: counter reload on every state change, handshake and pin next values.
   always_comb begin
      cnt_load     = (next_state != state);
      cnt_load_val = '0;
      case (next_state)
         ST_SETUP: cnt_load_val = cnt_t'(SETUP_CYC - 1);
         ST_PULSE: cnt_load_val = cnt_t'(EN_HIGH_CYC - 1);
         ST_HOLD:  cnt_load_val = cnt_t'(HOLD_CYC - 1);
         ST_EXEC:  cnt_load_val = long_q ? cnt_t'(LONG_EXEC_CYC - 1)
                                         : cnt_t'(EXEC_CYC - 1);
         default:  cnt_load_val = '0;
      endcase
      bus.req_ready = (state == ST_IDLE);
      en_nxt        = (next_state == ST_PULSE);
      done_nxt      = (state == ST_EXEC) && cnt_zero;
   end

   // Pin registers: RS/DATA change only on accept, so they are frozen across EN.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         LCD_RS   <= 1'b0;
         LCD_DATA <= 8'h00;
         LCD_EN   <= 1'b0;
         long_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         LCD_EN <= en_nxt;
         done_q <= done_nxt;
         if (accept) begin
            LCD_RS   <= bus.req_rs;
            LCD_DATA <= bus.req_data;
            long_q   <= is_long_cmd(bus.req_rs, bus.req_data);
         end
      end
   end

   assign bus.wr_done = done_q;
   assign LCD_RW      = 1'b0;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// tb_lcd_bus_driver: directed write cycles against scaled timing parameters.
// Normal busy = 4+12+2+20 = 38 cycles, long busy = 4+12+2+60 = 78 cycles.
// Also covers back-to-back accept, busy-time requests and mid-pulse reset.
module tb_lcd_bus_driver;
   import lcd_pkg::*;

   localparam int SETUP = 4;
   localparam int ENH   = 12;
   localparam int HOLD  = 2;
   localparam int EXEC  = 20;
   localparam int LONG  = 60;
   localparam int POR   = 30;
   localparam int NORM_BUSY = SETUP + ENH + HOLD + EXEC;
   localparam int LONG_BUSY = SETUP + ENH + HOLD + LONG;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       lcd_rs, lcd_rw, lcd_en;
   logic [7:0] lcd_data;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   lcd_bus_driver_if bus ();

   lcd_bus_driver #(
      .SETUP_CYC     (SETUP),
      .EN_HIGH_CYC   (ENH),
      .HOLD_CYC      (HOLD),
      .EXEC_CYC      (EXEC),
      .LONG_EXEC_CYC (LONG),
      .POR_CYC       (POR)
   ) dut (
      .CLOCK_50 (clk),
      .reset    (reset),
      .bus      (bus),
      .LCD_RS   (lcd_rs),
      .LCD_RW   (lcd_rw),
      .LCD_EN   (lcd_en),
      .LCD_DATA (lcd_data)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!bus.req_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready) check("ready_timeout", 32'd0, 32'd1);
   endtask

   // Issue one write and watch it until ready returns; i counts cycles after accept.
   task automatic run_write(input string tag, input logic rs, input logic [7:0] d,
                            input int busy, input bit noise);
      int       en_first = 0, en_cnt = 0, en_edges = 0;
      int       ready_at = 0, done_cnt = 0, done_at = 0;
      bit       stable = 1'b1, prev_en = 1'b0;
      logic [8:0] pins1 = '0;
      wait_ready();
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_rs    = rs;
      bus.req_data  = d;
      @(posedge clk);
      #1 bus.req_valid = noise;
      for (int i = 1; i <= 300; i++) begin
         @(negedge clk);
         if (i == 1) pins1 = {lcd_rs, lcd_data};
         if (noise) begin
            bus.req_data = 8'((i * 37) & 8'hff);
            bus.req_rs   = i[0];
            if (i == 30) bus.req_valid = 1'b0;
         end
         if (lcd_en) begin
            en_cnt++;
            if (en_first == 0) en_first = i;
            if (!prev_en) en_edges++;
            if ({lcd_rs, lcd_data} != {rs, d}) stable = 1'b0;
         end
         prev_en = lcd_en;
         if (bus.wr_done) begin
            done_cnt++;
            done_at = i;
         end
         if (bus.req_ready) begin
            ready_at = i;
            break;
         end
      end
      check({tag, "_pins"},     32'(pins1),    32'({rs, d}));
      check({tag, "_en_first"}, en_first,      SETUP + 1);
      check({tag, "_en_width"}, en_cnt,        ENH);
      check({tag, "_en_pulses"},en_edges,      1);
      check({tag, "_stable"},   32'(stable),   32'd1);
      check({tag, "_ready_at"}, ready_at,      busy + 1);
      check({tag, "_done_at"},  done_at,       busy + 1);
      check({tag, "_done_cnt"}, done_cnt,      1);
      check({tag, "_rw"},       32'(lcd_rw),   32'd0);
      @(negedge clk);
      check({tag, "_done_once"},32'(bus.wr_done), 32'd0);
      check({tag, "_pins_kept"},32'({lcd_rs, lcd_data}), 32'({rs, d}));
   endtask

   initial begin
      int bad_en, ready_at, done_cnt;
      bit seen;
      bus.req_valid = 1'b0;
      bus.req_rs    = 1'b0;
      bus.req_data  = 8'h00;
      reset = 1'b1;
      repeat (3) @(negedge clk);

      check("rst_en",   32'(lcd_en),      32'd0);
      check("rst_rs",   32'(lcd_rs),      32'd0);
      check("rst_rw",   32'(lcd_rw),      32'd0);
      check("rst_data", 32'(lcd_data),    32'h00);
      check("rst_done", 32'(bus.wr_done), 32'd0);
`ifdef LCD_BUS_POR_EN
      check("rst_ready", 32'(bus.req_ready), 32'd0);
      // Request held from reset release: ignored until POWERUP ends.
      bus.req_valid = 1'b1;
      bus.req_rs    = 1'b0;
      bus.req_data  = 8'h80;
      reset = 1'b0;
      ready_at = 0;
      for (int j = 1; j <= 200; j++) begin
         @(negedge clk);
         if (bus.req_ready) begin
            ready_at = j;
            break;
         end
         if (lcd_data != 8'h00) check("por_ignored", 32'(lcd_data), 32'h00);
      end
      check("por_ready_at", ready_at, POR);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      check("por_accept", 32'(lcd_data), 32'h80);
      wait_ready();
`else
      check("rst_ready", 32'(bus.req_ready), 32'd1);
      @(negedge clk);
      reset = 1'b0;
`endif

      run_write("d41",   1'b1, 8'h41, NORM_BUSY, 1'b0);
      run_write("clr01", 1'b0, 8'h01, LONG_BUSY, 1'b0);
      run_write("home02",1'b0, 8'h02, LONG_BUSY, 1'b0);
      run_write("home03",1'b0, 8'h03, LONG_BUSY, 1'b0);
      run_write("fs38",  1'b0, 8'h38, NORM_BUSY, 1'b0);
      run_write("d01",   1'b1, 8'h01, NORM_BUSY, 1'b0);
      run_write("em04",  1'b0, 8'h04, NORM_BUSY, 1'b0);
      run_write("busy",  1'b1, 8'h41, NORM_BUSY, 1'b1);

      // Back-to-back: valid held, second byte accepted in the wr_done cycle.
      wait_ready();
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_rs    = 1'b0;
      bus.req_data  = 8'h38;
      @(posedge clk);
      #1 bus.req_data = 8'h0C;
      bad_en = 0;
      seen = 1'b0;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (lcd_en && lcd_data != 8'h38) bad_en++;
         if (bus.wr_done) begin
            seen = 1'b1;
            break;
         end
      end
      check("b2b_done_seen", 32'(seen), 32'd1);
      check("b2b_ready_in_done", 32'(bus.req_ready), 32'd1);
      check("b2b_first_stable", bad_en, 0);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      check("b2b_second_data", 32'(lcd_data), 32'h0C);
      check("b2b_second_busy", 32'(bus.req_ready), 32'd0);
      bad_en = 0;
      for (int i = 2; i <= 200 && !bus.req_ready; i++) begin
         @(negedge clk);
         if (lcd_en && lcd_data != 8'h0C) bad_en++;
      end
      check("b2b_second_stable", bad_en, 0);

      // Reset on the 6th PULSE cycle drops the transaction.
      wait_ready();
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_rs    = 1'b1;
      bus.req_data  = 8'h5A;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      repeat (SETUP + 6) @(negedge clk);
      check("mid_en_high", 32'(lcd_en), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_en",   32'(lcd_en),   32'd0);
      check("mid_rst_data", 32'(lcd_data), 32'h00);
      check("mid_rst_rs",   32'(lcd_rs),   32'd0);
      reset = 1'b0;
      done_cnt = 0;
      ready_at = 0;
      for (int j = 1; j <= 150; j++) begin
         @(negedge clk);
         if (bus.wr_done) done_cnt++;
         if (bus.req_ready && ready_at == 0) ready_at = j;
      end
      check("mid_no_done", done_cnt, 0);
`ifdef LCD_BUS_POR_EN
      check("mid_por_ready_at", ready_at, POR);
`else
      check("mid_ready_at", ready_at, 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
